// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: ID-stage register usage and branch outcome in,
// hold/bubble/flush controls, EX forwarding selects and event counters out.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [4:0]       id_dst;
    logic             id_regwr;
    logic             id_memtoreg;
    logic             ex_br_taken;

    logic             stall_pc;
    logic             stall_ifid;
    logic             bubble_idex;
    logic             flush_ifid;
    logic [1:0]       ex_fwd_a;
    logic [1:0]       ex_fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_regwr, id_memtoreg, ex_br_taken,
        input  stall_pc, stall_ifid, bubble_idex, flush_ifid, ex_fwd_a, ex_fwd_b,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_regwr, id_memtoreg, ex_br_taken,
        output stall_pc, stall_ifid, bubble_idex, flush_ifid, ex_fwd_a, ex_fwd_b,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard scheduler for a 5-stage pipeline: EX/MEM/WR scoreboard, RAW/load-use stalls,
// taken-branch flush sequencing. Define PIPE_FWD_EN to enable EX operand forwarding.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    typedef struct packed {
        logic [4:0] dst;
        logic       regwr;
        logic       memtoreg;
    } slot_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_e           state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    slot_t            ex_q, ex_d, mem_q, mem_d, wr_q, wr_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic [2:0] hit_a, hit_b;   // [0]=EX, [1]=MEM, [2]=WR
    logic       hazard;
    logic [1:0] fwd_a_id, fwd_b_id;
    logic       br_take, stall, bubble, flush;
    logic       unused_wr_memtoreg;

    function automatic logic slot_hit(slot_t s, logic [4:0] src, logic rd_en);
        return rd_en && s.regwr && (s.dst != 5'd0) && (s.dst == src);
    endfunction

    // NOTE: each always_comb assigns defaults first so no path leaves a variable unassigned (no latches).
    always_comb begin
        hit_a    = {slot_hit(wr_q, hz.id_rs, hz.id_use_rs),
                    slot_hit(mem_q, hz.id_rs, hz.id_use_rs),
                    slot_hit(ex_q, hz.id_rs, hz.id_use_rs)};
        hit_b    = {slot_hit(wr_q, hz.id_rt, hz.id_use_rt),
                    slot_hit(mem_q, hz.id_rt, hz.id_use_rt),
                    slot_hit(ex_q, hz.id_rt, hz.id_use_rt)};
        hazard   = 1'b0;
        fwd_a_id = 2'b00;
        fwd_b_id = 2'b00;
`ifdef PIPE_FWD_EN
        // Loads only have data after MEM; WR matches read a register file written this same edge.
        hazard   = ((hit_a[0] | hit_b[0]) & ex_q.memtoreg) | hit_a[2] | hit_b[2];
        fwd_a_id = hit_a[0] ? 2'b01 : (hit_a[1] ? 2'b10 : 2'b00);
        fwd_b_id = hit_b[0] ? 2'b01 : (hit_b[1] ? 2'b10 : 2'b00);
`else
        hazard   = |{hit_a, hit_b};
`endif
    end

    // NOTE: registers are updated only with non-blocking assignments to avoid races with the comb logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            fcnt_q      <= 3'd0;
            ex_q        <= '0;
            mem_q       <= '0;
            wr_q        <= '0;
            fwd_a_q     <= 2'b00;
            fwd_b_q     <= 2'b00;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wr_q        <= wr_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        br_take = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (hz.ex_br_taken) begin
                    br_take = 1'b1;
                    fcnt_d  = FLUSH_LOAD;
                    if (FLUSH_LOAD != 3'd0) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // A branch seen here is ignored: EX holds a bubble by construction.
                fcnt_d = fcnt_q - 3'd1;
                if (fcnt_q <= 3'd1) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        stall  = 1'b0;
        flush  = 1'b0;
        bubble = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_RUN: begin
                    flush = br_take;
                    stall = !br_take && hazard;
                end
                ST_FLUSH: flush = 1'b1;
                default: ;
            endcase
            bubble = flush | stall;
        end
    end

    always_comb begin
        ex_d        = '0;
        if (!bubble && !rst) ex_d = {hz.id_dst, hz.id_regwr, hz.id_memtoreg};
        mem_d       = ex_q;
        wr_d        = mem_q;
        fwd_a_d     = bubble ? 2'b00 : fwd_a_id;
        fwd_b_d     = bubble ? 2'b00 : fwd_b_id;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (br_take && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    assign unused_wr_memtoreg = wr_q.memtoreg;

    assign hz.stall_pc    = stall;
    assign hz.stall_ifid  = stall;
    assign hz.bubble_idex = bubble;
    assign hz.flush_ifid  = flush;
    assign hz.ex_fwd_a    = fwd_a_q;
    assign hz.ex_fwd_b    = fwd_b_q;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard scheduler for the 5-stage pipeline (IF, ID, EX, MEM, WR).
- Keeps a 3-slot scoreboard of in-flight destination registers for the EX, MEM and WR stages.
- Detects RAW and load-use hazards for the instruction in ID, and sequences stalls and branch flushes.
- Drives the hold, bubble and flush controls of the pipeline registers plus the EX-stage operand-forwarding selects.

Parameters:
- FLUSH_CYCLES, 2: number of cycles flush_ifid stays asserted after a taken branch; legal range 1..7.
- CNT_W, 16: width of the stall and flush event counters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_rs  in  5  Rs field of the ID instruction
- id_rt  in  5  Rt field of the ID instruction
- id_use_rs  in  1  ID instruction reads Rs
- id_use_rt  in  1  ID instruction reads Rt
- id_dst  in  5  ID destination register, after the RegDst mux
- id_regwr  in  1  ID instruction writes the register file
- id_memtoreg  in  1  ID instruction is lw
- ex_br_taken  in  1  branch in EX resolved taken (nPC_sel)
- stall_pc  out  1  hold the PC
- stall_ifid  out  1  hold IF/ID
- bubble_idex  out  1  load a NOP (all controls 0) into ID/EX
- flush_ifid  out  1  clear IF/ID to a NOP
- ex_fwd_a  out  2  EX operand A source: 00 regfile, 01 EX/MEM ALUout, 10 MEM/WR busW
- ex_fwd_b  out  2  same encoding, for operand B
- stall_cnt  out  CNT_W  cycles spent stalled
- flush_cnt  out  CNT_W  taken branches flushed

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset clears all scoreboard slots (regwr=0, dst=0), sets state RUN, flush counter 0, ex_fwd_a/b 00, stall_cnt and flush_cnt 0. All control outputs are 0 while rst is high.
- Scoreboard slot = {dst, regwr, memtoreg}. A slot matches a source register iff regwr=1, dst!=0, dst==src, and the corresponding use bit is 1.
- The scoreboard shifts every cycle: EX<=ID-or-empty, MEM<=EX, WR<=MEM. The WR slot retires.
- The EX slot loads the ID fields only when neither bubble_idex nor rst is set; otherwise it loads empty.
- Hazard (with forwarding):
  - stall if the EX slot matches and EX.memtoreg=1 (load-use, 1 cycle);
  - stall if the WR slot matches (regfile is written on the same edge, so the ID read is stale).
- Forward selects, computed in ID and registered into ex_fwd_* when ID/EX advances:
  - EX-slot match gives 01; else MEM-slot match gives 10; else 00.
  - The youngest match wins.
  - On a bubble, ex_fwd_* <= 00.
- State machine:
  - RUN: a hazard asserts stall_pc=stall_ifid=bubble_idex=1 combinationally; the state stays RUN and re-evaluates each cycle.
  - RUN to FLUSH: on ex_br_taken=1, load the counter with FLUSH_CYCLES-1; assert flush_ifid=1 and bubble_idex=1 that cycle; increment flush_cnt.
  - FLUSH: flush_ifid=1 and bubble_idex=1; stalls are suppressed; the ID instruction is ignored for hazard checks. The counter decrements and the state returns to RUN when it reaches 0.
  - FLUSH_CYCLES=1: the machine never enters FLUSH.
- Simultaneous events:
  - A taken branch overrides a concurrent stall (stall_* = 0 that cycle).
  - ex_br_taken during FLUSH is ignored, since EX holds a bubble by construction.
- Counters:
  - stall_cnt increments each cycle stall_pc=1; flush_cnt increments per taken branch.
  - Both saturate at all-ones; there is no wrap.
- rst asserted mid-stall or mid-flush: the next cycle is in RUN with an empty scoreboard and all outputs 0.

Optional Feature:
- Macro: PIPE_FWD_EN.
- Defined: forwarding as above.
- Undefined:
  - ex_fwd_a/b are tied to 00.
  - Any match in the EX, MEM or WR slot stalls, regardless of memtoreg.
  - A dependent instruction stalls until its producer has retired from WR: 3 cycles when the producer is in EX.

Test Plan:
- Reset: hold rst for 2 cycles with ex_br_taken=1 -> all outputs 0; counters 0; no FLUSH entry.
- add $3,$1,$2 then sub $4,$3,$5 (fwd on) -> no stall; ex_fwd_a=01 in sub's EX cycle. With a gap of one unrelated instruction -> ex_fwd_a=10.
- lw $8,0($0) then add $9,$8,$8 (fwd on) -> exactly 1 stall cycle with bubble_idex=1; then ex_fwd_a=ex_fwd_b=10; stall_cnt=1.
- Same add dependency with PIPE_FWD_EN undefined -> 3 consecutive stall cycles; ex_fwd_* stays 00; stall_cnt=3.
- ex_br_taken=1 for 1 cycle, FLUSH_CYCLES=2 -> flush_ifid high 2 cycles, bubble_idex high 2 cycles, flush_cnt=1. Load-use pending in that same cycle -> stall_pc=0.
- Writes to $0 followed by reads of $0 -> never stall, fwd 00.
- Force stall_cnt to all-ones minus 1, run 3 stall cycles -> holds at all-ones.
